// File: rtl/s_pl_reg_vdly.sv
// Run-time selectable delay line for data plus valid, 0..MAXDLY stages.
// Latency: cur_dly en=1 edges (0 = combinational bypass); outputs come straight from stage flops.
// No back-pressure: en stalls the whole line, and samples leaving on an en=1 edge are not held.
module s_pl_reg_vdly #(
  parameter int              SIZE    = 8,
  parameter int              MAXDLY  = 15,
  parameter int              DLYW    = 4,
  parameter int              DEF_DLY = 3,
  parameter logic [SIZE-1:0] RST_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            flush,
  input  logic            dly_ld,
  input  logic [DLYW-1:0] dly_val,
  input  logic [SIZE-1:0] idat,
  input  logic            ivld,
  output logic [SIZE-1:0] odat,
  output logic            ovld,
  output logic [DLYW-1:0] cur_dly,
  output logic [DLYW-1:0] fill,
  output logic            dly_err
);

  localparam logic [DLYW-1:0] MAXDLY_W  = DLYW'(MAXDLY);
  localparam logic [DLYW-1:0] DEF_DLY_W = DLYW'(DEF_DLY);

  // Index 0 holds stage 1 (youngest sample), index MAXDLY-1 holds the oldest.
  logic [SIZE-1:0]   s_q [MAXDLY];
  logic [SIZE-1:0]   s_d [MAXDLY];
  logic [MAXDLY-1:0] v_q, v_d;
  logic [DLYW-1:0]   cur_dly_q, cur_dly_d;
  logic [DLYW-1:0]   fill_q, fill_d;
  logic              dly_err_q, dly_err_d;

  // Tap of the stage selected by cur_dly; cur_dly never exceeds MAXDLY.
  logic [SIZE-1:0]   tap_dat;
  logic              tap_vld;

  // Select the active output stage.
  always_comb begin
    tap_dat = RST_VAL;
    tap_vld = 1'b0;
    for (int k = 0; k < MAXDLY; k++) begin
      if (cur_dly_q == DLYW'(k + 1)) begin
        tap_dat = s_q[k];
        tap_vld = v_q[k];
      end
    end
  end

  // Delay 0 bypasses the stages entirely; otherwise drive from the selected flop.
  always_comb begin
    if (cur_dly_q == '0) begin
      odat = idat;
      ovld = ivld;
    end else begin
      odat = tap_dat;
      ovld = tap_vld;
    end
  end

  assign cur_dly = cur_dly_q;
  assign fill    = fill_q;
  assign dly_err = dly_err_q;

  // Next-state: shift on en, then flush/load clear the valids and occupancy.
  always_comb begin
    s_d       = s_q;
    v_d       = v_q;
    fill_d    = fill_q;
    cur_dly_d = cur_dly_q;
    dly_err_d = 1'b0;
    if (en) begin
      s_d[0] = idat;
      v_d[0] = ivld;
      for (int k = 1; k < MAXDLY; k++) begin
        s_d[k] = s_q[k-1];
        v_d[k] = v_q[k-1];
      end
      // Occupancy only tracks the window when the stages are in use.
      if (cur_dly_q != '0) begin
        fill_d = fill_q + DLYW'(ivld) - DLYW'(tap_vld);
      end
    end
    // Clearing every valid also drops the sample entering on this edge.
    if (flush || dly_ld) begin
      v_d    = '0;
      fill_d = '0;
    end
    if (dly_ld) begin
      cur_dly_d = (dly_val > MAXDLY_W) ? MAXDLY_W : dly_val;
      dly_err_d = (dly_val > MAXDLY_W);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MAXDLY; k++) begin
        s_q[k] <= RST_VAL;
      end
      v_q       <= '0;
      cur_dly_q <= DEF_DLY_W;
      fill_q    <= '0;
      dly_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < MAXDLY; k++) begin
        s_q[k] <= s_d[k];
      end
      v_q       <= v_d;
      cur_dly_q <= cur_dly_d;
      fill_q    <= fill_d;
      dly_err_q <= dly_err_d;
    end
  end

endmodule

// File: tb/tb_s_pl_reg_vdly.sv
module tb_s_pl_reg_vdly;

  localparam int SIZE   = 8;
  localparam int MAXDLY = 7;
  localparam int DLYW   = 4;
  localparam int DEFD   = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            en = 1'b0;
  logic            flush = 1'b0;
  logic            dly_ld = 1'b0;
  logic [DLYW-1:0] dly_val = '0;
  logic [SIZE-1:0] idat = '0;
  logic            ivld = 1'b0;
  logic [SIZE-1:0] odat;
  logic            ovld;
  logic [DLYW-1:0] cur_dly;
  logic [DLYW-1:0] fill;
  logic            dly_err;

  s_pl_reg_vdly #(
    .SIZE(SIZE), .MAXDLY(MAXDLY), .DLYW(DLYW), .DEF_DLY(DEFD), .RST_VAL('0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .dly_ld(dly_ld),
    .dly_val(dly_val), .idat(idat), .ivld(ivld), .odat(odat), .ovld(ovld),
    .cur_dly(cur_dly), .fill(fill), .dly_err(dly_err)
  );

  always #5 clk = ~clk;

  // Reference model: the full history of samples entered on en edges, plus
  // the history position of the latest flush/load (everything before is dead).
  typedef struct { logic [SIZE-1:0] d; bit v; } ent_t;
  ent_t hist[$];
  int   clear_n;
  int   m_dly;
  bit   m_err;

  typedef struct { bit ovld; logic [SIZE-1:0] odat; int fill; int dly; bit err; } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("ovld", int'(ovld), int'(e.ovld));
        if (e.ovld) chk("odat", int'(odat), int'(e.odat));
        chk("fill", int'(fill), e.fill);
        chk("cur_dly", int'(cur_dly), e.dly);
        chk("dly_err", int'(dly_err), int'(e.err));
      end
    end
  end

  task automatic model_reset();
    hist.delete();
    clear_n = 0;
    m_dly = DEFD;
    m_err = 1'b0;
  endtask

  // Expected outputs for the current state and the inputs now applied.
  function automatic exp_t predict(input bit i_v, input logic [SIZE-1:0] i_d);
    exp_t e;
    int n, idx, lo;
    n = hist.size();
    e.dly = m_dly;
    e.err = m_err;
    e.fill = 0;
    e.ovld = 1'b0;
    e.odat = '0;
    if (m_dly == 0) begin
      e.ovld = i_v;
      e.odat = i_d;
    end else begin
      idx = n - m_dly;
      if (idx >= 0 && idx >= clear_n && hist[idx].v) begin
        e.ovld = 1'b1;
        e.odat = hist[idx].d;
      end
      lo = idx;
      if (lo < clear_n) lo = clear_n;
      if (lo < 0) lo = 0;
      for (int i = lo; i < n; i++) if (hist[i].v) e.fill++;
    end
    return e;
  endfunction

  task automatic step(input bit e_en, input bit e_v, input logic [SIZE-1:0] e_d,
                      input bit e_fl, input bit e_ld, input logic [DLYW-1:0] e_val);
    ent_t ent;
    en = e_en; ivld = e_v; idat = e_d; flush = e_fl; dly_ld = e_ld; dly_val = e_val;
    sb.push_back(predict(e_v, e_d));
    @(posedge clk);
    #1;
    if (e_en) begin
      ent.d = e_d;
      ent.v = e_v && !e_fl && !e_ld;
      hist.push_back(ent);
    end
    if (e_fl || e_ld) clear_n = hist.size();
    m_err = 1'b0;
    if (e_ld) begin
      m_dly = (int'(e_val) > MAXDLY) ? MAXDLY : int'(e_val);
      m_err = (int'(e_val) > MAXDLY);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = $urandom_range(0, 1); ivld = 1'b1; flush = 1'b0; dly_ld = 1'b1; dly_val = 4'd9;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run(input int cnt);
    for (int i = 0; i < cnt; i++)
      step(1'b1, 1'b1, SIZE'($urandom), 1'b0, 1'b0, '0);
  endtask

  initial begin
    bit   r_ld, r_fl;
    int   wait_cyc;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Contiguous stream at the reset delay.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, SIZE'(8'h10 + i), 1'b0, 1'b0, '0);
    // Stall mid-stream.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, SIZE'($urandom), 1'b0, 1'b0, '0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, SIZE'(8'h1a + i), 1'b0, 1'b0, '0);
    // Delay change with samples in flight.
    step(1'b1, 1'b1, 8'hee, 1'b0, 1'b1, 4'd5);
    run(10);
    // Clamp, then bypass.
    step(1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 4'd15);
    run(9);
    step(1'b1, 1'b1, 8'h66, 1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 6; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), SIZE'($urandom), 1'b0, 1'b0, '0);
    // Flush at full occupancy.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 4'd4);
    run(6);
    step(1'b1, 1'b1, 8'h77, 1'b1, 1'b0, '0);
    run(8);
    // Sparse valid pattern at delay 2.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 4'd2);
    step(1'b1, 1'b1, 8'ha1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 8'ha2, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 8'ha3, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 8'ha4, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 8'ha5, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, '0);
    // Mid-stream reset.
    do_reset();
    run(5);

    // Randomised traffic.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        r_ld = ($urandom_range(0, 39) == 0);
        r_fl = ($urandom_range(0, 29) == 0);
        step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) < 3), SIZE'($urandom),
             r_fl, r_ld, DLYW'($urandom_range(0, 15)));
      end
    end
    en = 1'b0; ivld = 1'b0; flush = 1'b0; dly_ld = 1'b0;

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (sb.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
